// File: rtl/latch_arb_pkg.sv
// Shared types and defaults for the latched-write arbiter.
package latch_arb_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned TO_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WRITE,
    HOLD
  } arb_state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates N_REQ requesters onto one storage register, four-phase handshake.
// Optional HOLD timeout enabled by defining ARB_TIMEOUT_EN.
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    en_out,
  output logic [DATA_W-1:0]       d_out,
  output logic [DATA_W-1:0]       q_out,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned PTR_W = ptr_width(N_REQ);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, win_idx_q, win_idx_d, pick_idx;
  logic [N_REQ-1:0]  grant_q, grant_d, pick;
  logic              pick_valid;
  logic [DATA_W-1:0] d_q, d_d, q_q, q_d;
  logic              win_req, timeout;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign win_req = |(req & grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TO_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout = (state_q == HOLD) && win_req && (cnt_q == CNT_W'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == HOLD) ? cnt_q + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
  assign timeout       = 1'b0;
  assign err           = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    grant_d   = grant_q;
    d_d       = d_q;
    q_d       = q_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = GRANT;
          grant_d   = pick;
          win_idx_d = pick_idx;
          d_d       = data_in[pick_idx*DATA_W +: DATA_W];
        end
      end
      GRANT: state_d = WRITE;
      WRITE: begin
        state_d = HOLD;
        q_d     = d_q;
      end
      HOLD: begin
        if (!win_req || timeout) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (win_idx_q == PTR_W'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      grant_q   <= '0;
      d_q       <= '0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      grant_q   <= grant_d;
      d_q       <= d_d;
      q_q       <= q_d;
    end
  end

  // Gated by rst so a reset landing in WRITE never produces a write strobe.
  assign en_out = (state_q == WRITE) && !rst;
  assign grant  = grant_q;
  assign ack    = (state_q == HOLD) ? grant_q : '0;
  assign d_out  = d_q;
  assign q_out  = q_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: vector table, hand sequences, write scoreboard.
module tb_latch_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant, ack;
  logic        en_out, busy, err;
  logic [7:0]  d_out, q_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  latch_write_arbiter #(
    .N_REQ  (4),
    .DATA_W (8),
    .TO_CYC (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .ack     (ack),
    .en_out  (en_out),
    .d_out   (d_out),
    .q_out   (q_out),
    .busy    (busy),
    .err     (err)
  );

  typedef struct {
    logic [3:0]  grant;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          n;
    logic [15:0] seq;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[7];
  logic       q_pending = 1'b0;
  logic [7:0] q_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic push_wr(input logic [3:0] g, input logic [31:0] d);
    wr_t w;
    w.grant = g;
    w.data  = d[oh2idx(g)*8 +: 8];
    sb.push_back(w);
  endtask

  // Every write strobe must match the next expected write; stored word follows one cycle later.
  always @(negedge clk) begin
    if (q_pending) begin
      chk("q_after_write", {24'h0, q_out}, {24'h0, q_exp});
      q_pending = 1'b0;
    end
    if (en_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_en_out", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("wr_grant", {28'h0, grant}, {28'h0, w.grant});
        chk("wr_data", {24'h0, d_out}, {24'h0, w.data});
        q_exp     = w.data;
        q_pending = 1'b1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, {28'h0, grant}, 32'h0);
    chk({tag, "_ack"}, {28'h0, ack}, 32'h0);
    chk({tag, "_en"}, {31'h0, en_out}, 32'h0);
    chk({tag, "_dout"}, {24'h0, d_out}, 32'h0);
    chk({tag, "_qout"}, {24'h0, q_out}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    data_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits up to a bounded number of cycles for the selected output to go nonzero.
  task automatic wait_nz(input bit use_ack, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((use_ack ? ack : grant) == 4'b0) && n < 12);
    if (n >= 12) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{req: 4'b1111, data: 32'h44332211, n: 4, seq: {4'b1000, 4'b0100, 4'b0010, 4'b0001}};
    tbl[1] = '{req: 4'b0001, data: 32'h00000055, n: 1, seq: {12'h0, 4'b0001}};
    tbl[2] = '{req: 4'b0101, data: 32'h00770066, n: 2, seq: {8'h0, 4'b0001, 4'b0100}};
    tbl[3] = '{req: 4'b0110, data: 32'h00998800, n: 2, seq: {8'h0, 4'b0100, 4'b0010}};
    tbl[4] = '{req: 4'b1001, data: 32'hBB0000AA, n: 2, seq: {8'h0, 4'b0001, 4'b1000}};
    tbl[5] = '{req: 4'b1010, data: 32'hC300C100, n: 2, seq: {8'h0, 4'b1000, 4'b0010}};
    tbl[6] = '{req: 4'b0011, data: 32'h0000D2D1, n: 2, seq: {8'h0, 4'b0010, 4'b0001}};

    do_reset();
    check_reset_vals("reset");

    // Reset during GRANT aborts the write.
    req = 4'b0010;
    data_in = 32'h00007700;
    @(negedge clk);
    chk("abort_grant_seen", {28'h0, grant}, 32'h2);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("abort_after");

    // Single request latency: cycle 0 req, cycle 2 en_out, cycle 3 q_out/ack.
    req = 4'b0001;
    data_in = 32'h000000A5;
    push_wr(4'b0001, data_in);
    @(negedge clk);
    chk("lat_c1_grant", {28'h0, grant}, 32'h1);
    chk("lat_c1_en", {31'h0, en_out}, 32'h0);
    chk("lat_c1_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("lat_c2_en", {31'h0, en_out}, 32'h1);
    chk("lat_c2_q_old", {24'h0, q_out}, 32'h0);
    @(negedge clk);
    chk("lat_c3_en", {31'h0, en_out}, 32'h0);
    chk("lat_c3_q", {24'h0, q_out}, 32'hA5);
    chk("lat_c3_ack", {28'h0, ack}, 32'h1);
    @(negedge clk);
    chk("lat_c4_ack", {28'h0, ack}, 32'h1);
    req = '0;
    @(negedge clk);
    chk("lat_c5_ack", {28'h0, ack}, 32'h0);
    chk("lat_c5_grant", {28'h0, grant}, 32'h0);
    chk("lat_c5_busy", {31'h0, busy}, 32'h0);

    // Vector table from a fresh reset: ptr restarts at 0.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      req = tbl[v].req;
      data_in = tbl[v].data;
      for (int g = 0; g < tbl[v].n; g++) push_wr(tbl[v].seq[g*4 +: 4], tbl[v].data);
      for (int g = 0; g < tbl[v].n; g++) begin
        logic [3:0] eg;
        eg = tbl[v].seq[g*4 +: 4];
        wait_nz(1'b0, "tbl_grant");
        chk($sformatf("tbl%0d_grant%0d", v, g), {28'h0, grant}, {28'h0, eg});
        wait_nz(1'b1, "tbl_ack");
        chk($sformatf("tbl%0d_ack%0d", v, g), {28'h0, ack}, {28'h0, eg});
        req = req & ~eg;
        @(negedge clk);
        chk($sformatf("tbl%0d_idle%0d", v, g), {31'h0, busy}, 32'h0);
      end
    end

    // Winner drops req during WRITE: write still commits, one-cycle ack.
    req = 4'b0100;
    data_in = 32'h00E70000;
    push_wr(4'b0100, data_in);
    @(negedge clk);
    chk("drop_grant", {28'h0, grant}, 32'h4);
    @(negedge clk);
    chk("drop_write_en", {31'h0, en_out}, 32'h1);
    req = '0;
    @(negedge clk);
    chk("drop_ack", {28'h0, ack}, 32'h4);
    @(negedge clk);
    chk("drop_ack_gone", {28'h0, ack}, 32'h0);
    chk("drop_idle", {31'h0, busy}, 32'h0);

    // Winner holds req for 20 cycles.
    begin
      int  ack_cycles = 0;
      bit  ended = 1'b0;
`ifdef ARB_TIMEOUT_EN
      int  exp_cycles = 15;
      logic exp_err = 1'b1;
`else
      int  exp_cycles = 20;
      logic exp_err = 1'b0;
`endif
      req = 4'b1000;
      data_in = 32'hF0000000;
      push_wr(4'b1000, data_in);
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!ended && ack == 4'b1000) ack_cycles++;
        else begin
          ended = 1'b1;
`ifdef ARB_TIMEOUT_EN
          req = '0;
`endif
        end
      end
      req = '0;
      chk("hold_ack_cycles", ack_cycles, exp_cycles);
      @(negedge clk);
      @(negedge clk);
      chk("hold_err", {31'h0, err}, {31'h0, exp_err});
      chk("hold_idle", {31'h0, busy}, 32'h0);
    end

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
